// File: rtl/requant_relu_stage.sv
// requant_relu_stage
// Requantizes signed accumulator results from the multiply-and-add array into
// signed activations for the next layer: fixed-point scale, round-half-up
// shift, zero-point offset, optional ReLU floor and saturation. Two-stage
// elastic pipeline with valid/ready on both sides and a sticky saturation
// event counter used during calibration.
module requant_relu_stage #(
    parameter int RESULT_WIDTH = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int MULT_WIDTH   = 16,
    parameter int SHIFT_WIDTH  = 5,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [RESULT_WIDTH-1:0] in_value,
    input  logic                           in_last,
    input  logic        [MULT_WIDTH-1:0]   scale_mult,
    input  logic        [SHIFT_WIDTH-1:0]  scale_shift,
    input  logic signed [DATA_WIDTH-1:0]   zero_point,
    input  logic                           relu_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [DATA_WIDTH-1:0]   out_value,
    output logic                           out_last,
    input  logic                           sat_clear,
    output logic        [COUNT_WIDTH-1:0]  sat_count
);

    // Product width: signed accumulator times zero-extended unsigned scale.
    localparam int PW = RESULT_WIDTH + MULT_WIDTH + 1;
    // One extra bit so adding the rounding half can never overflow.
    localparam int RW = PW + 1;
    // One extra bit so adding the zero point can never overflow.
    localparam int VW = RW + 1;

    localparam logic signed [VW-1:0] HI_V  = {{(VW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [VW-1:0] MIN_V = {{(VW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic        [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

    // Arithmetic right shift with round-half-toward-+inf; shift 0 is a pass-through.
    function automatic logic signed [RW-1:0] round_shift(
        input logic signed [PW-1:0]          p,
        input logic        [SHIFT_WIDTH-1:0] sh
    );
        logic signed [RW-1:0] ext;
        logic signed [RW-1:0] half;
        ext  = {p[PW-1], p};
        half = {{(RW-1){1'b0}}, 1'b1} << (sh - SHIFT_WIDTH'(1));
        if (sh == '0) begin
            return ext;
        end
        return (ext + half) >>> sh;
    endfunction

    // Adds the sign-extended zero point at full precision.
    function automatic logic signed [VW-1:0] add_zero_point(
        input logic signed [RW-1:0]         r,
        input logic signed [DATA_WIDTH-1:0] zp
    );
        logic signed [VW-1:0] r_ext;
        logic signed [VW-1:0] zp_ext;
        r_ext  = {r[RW-1], r};
        zp_ext = {{(VW-DATA_WIDTH){zp[DATA_WIDTH-1]}}, zp};
        return r_ext + zp_ext;
    endfunction

    // Saturation event: value outside the representable output range.
    // The ReLU floor is a deliberate clamp and does not count.
    function automatic logic is_saturated(input logic signed [VW-1:0] v);
        return (v > HI_V) || (v < MIN_V);
    endfunction

    // Clamp to [lo, hi] where lo is the zero point under ReLU, else the type minimum.
    function automatic logic signed [DATA_WIDTH-1:0] clamp_out(
        input logic signed [VW-1:0]         v,
        input logic signed [DATA_WIDTH-1:0] zp,
        input logic                         relu
    );
        logic signed [VW-1:0] lo;
        if (relu) begin
            lo = {{(VW-DATA_WIDTH){zp[DATA_WIDTH-1]}}, zp};
        end else begin
            lo = MIN_V;
        end
        if (v > HI_V) begin
            return HI_V[DATA_WIDTH-1:0];
        end else if (v < lo) begin
            return lo[DATA_WIDTH-1:0];
        end
        return v[DATA_WIDTH-1:0];
    endfunction

    // Handshake / control
    logic vld_p1;
    logic vld_p2;
    logic s1_advance;

    // Stage 1 registers
    logic signed [PW-1:0]          prod_p1;
    logic        [SHIFT_WIDTH-1:0] shift_p1;
    logic signed [DATA_WIDTH-1:0]  zp_p1;
    logic                          relu_p1;
    logic                          last_p1;

    // Stage 2 registers
    logic signed [DATA_WIDTH-1:0]  value_p2;
    logic                          last_p2;
    logic                          sat_p2;

    logic [COUNT_WIDTH-1:0]        sat_count_q;

    // Operand extension for the stage-1 multiply
    logic signed [PW-1:0]          in_ext;
    logic signed [PW-1:0]          mult_ext;

    // Stage-2 combinational datapath fed from stage-1 registers
    logic signed [RW-1:0]          rnd_p1;
    logic signed [VW-1:0]          sum_p1;

    assign in_ext   = {{(PW-RESULT_WIDTH){in_value[RESULT_WIDTH-1]}}, in_value};
    assign mult_ext = {{(PW-MULT_WIDTH){1'b0}}, scale_mult};

    assign rnd_p1 = round_shift(prod_p1, shift_p1);
    assign sum_p1 = add_zero_point(rnd_p1, zp_p1);

    // Stage 1 may move on when stage 2 is empty or is being drained this edge.
    assign s1_advance = !vld_p2 || out_ready;
    assign in_ready   = !vld_p1 || s1_advance;

    assign out_valid = vld_p2;
    assign out_value = value_p2;
    assign out_last  = last_p2;
    assign sat_count = sat_count_q;

    // Stage valid flags: stage 1 reloads whenever it can accept, stage 2 whenever stage 1 advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (in_ready) begin
                vld_p1 <= in_valid;
            end
            if (s1_advance) begin
                vld_p2 <= vld_p1;
            end
        end
    end

    // Stage 1 data: scale product and per-beat config captured on input transfer.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            prod_p1  <= in_ext * mult_ext;
            shift_p1 <= scale_shift;
            zp_p1    <= zero_point;
            relu_p1  <= relu_en;
            last_p1  <= in_last;
        end
    end

    // Stage 2 output registers: round, offset, clamp; held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_p2 <= '0;
            last_p2  <= 1'b0;
            sat_p2   <= 1'b0;
        end else if (s1_advance && vld_p1) begin
            value_p2 <= clamp_out(sum_p1, zp_p1, relu_p1);
            last_p2  <= last_p1;
            sat_p2   <= is_saturated(sum_p1);
        end
    end

    // Saturation counter: counts delivered saturated beats, sticks at max, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_q <= '0;
        end else if (sat_clear) begin
            sat_count_q <= '0;
        end else if (vld_p2 && out_ready && sat_p2 && (sat_count_q != CNT_MAX)) begin
            sat_count_q <= sat_count_q + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_requant_relu_stage.sv
// Testbench for requant_relu_stage: directed scenarios plus a randomized
// stream checked against a behavioural requantization model.
module tb_requant_relu_stage;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_value;
    logic               in_last;
    logic        [15:0] scale_mult;
    logic        [4:0]  scale_shift;
    logic signed [7:0]  zero_point;
    logic               relu_en;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_value;
    logic               out_last;
    logic               sat_clear;
    logic        [15:0] sat_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int val;
        bit last;
        bit sat;
    } beat_t;

    requant_relu_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .in_last     (in_last),
        .scale_mult  (scale_mult),
        .scale_shift (scale_shift),
        .zero_point  (zero_point),
        .relu_en     (relu_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_last    (out_last),
        .sat_clear   (sat_clear),
        .sat_count   (sat_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Requantization reference: exact integer arithmetic with floor division.
    function automatic beat_t model(int inv, int mult, int sh, int zp, bit relu, bit last);
        longint p, num, den, r, v, lo;
        beat_t b;
        p = longint'(inv) * longint'(mult);
        if (sh == 0) begin
            r = p;
        end else begin
            den = longint'(1) << sh;
            num = p + den / 2;
            r = num / den;
            if ((num % den != 0) && (num < 0)) r = r - 1;
        end
        v  = r + longint'(zp);
        lo = relu ? longint'(zp) : -128;
        b.sat  = (v > 127) || (v < -128);
        b.val  = (v > 127) ? 127 : ((v < lo) ? int'(lo) : int'(v));
        b.last = last;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(int v, int m, int s, int zp, bit relu, bit last);
        in_value    = 16'(v);
        scale_mult  = 16'(m);
        scale_shift = 5'(s);
        zero_point  = 8'(zp);
        relu_en     = relu;
        in_last     = last;
    endtask

    // Sends one beat with out_ready high and returns what appeared two cycles later.
    task automatic run_beat(int v, int m, int s, int zp, bit relu,
                            output int got, output bit early_vld, output bit got_vld);
        out_ready = 1'b1;
        set_beat(v, m, s, zp, relu, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        early_vld = out_valid;
        step();
        got_vld = out_valid;
        got     = int'(out_value);
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; sat_clear = 1'b0;
        set_beat(0, 0, 0, 0, 1'b0, 1'b0);
        repeat (3) step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid); else n_pass++;
        n_checks++; if (out_value !== 8'sd0) $display("FAIL reset_out_value: got %0d expected 0", out_value); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %0b expected 0", out_last); else n_pass++;
        n_checks++; if (sat_count !== 16'd0) $display("FAIL reset_sat_count: got %0d expected 0", sat_count); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b expected 1", in_ready); else n_pass++;
        step();
    endtask

    task automatic test_scaling();
        int got; bit e, g;
        run_beat(200, 16384, 15, 0, 1'b0, got, e, g);
        n_checks++; if (e !== 1'b0) $display("FAIL scale_latency_early: got out_valid=%0b expected 0", e); else n_pass++;
        n_checks++; if (g !== 1'b1) $display("FAIL scale_latency: got out_valid=%0b expected 1", g); else n_pass++;
        n_checks++; if (got != 100) $display("FAIL scale_value: got %0d expected 100", got); else n_pass++;
        n_checks++; if (sat_count !== 16'd0) $display("FAIL scale_sat_count: got %0d expected 0", sat_count); else n_pass++;
    endtask

    task automatic test_rounding();
        int got; bit e, g;
        run_beat(3, 1, 1, 0, 1'b0, got, e, g);
        n_checks++; if (got != 2 || !g) $display("FAIL round_pos_half: got %0d (valid %0b) expected 2", got, g); else n_pass++;
        run_beat(-3, 1, 1, 0, 1'b0, got, e, g);
        n_checks++; if (got != -1 || !g) $display("FAIL round_neg_half: got %0d (valid %0b) expected -1", got, g); else n_pass++;
        run_beat(5, 1, 0, 0, 1'b0, got, e, g);
        n_checks++; if (got != 5 || !g) $display("FAIL round_shift0: got %0d (valid %0b) expected 5", got, g); else n_pass++;
    endtask

    task automatic test_relu_zero_point();
        int got; bit e, g;
        run_beat(-50, 1, 0, 0, 1'b1, got, e, g);
        n_checks++; if (got != 0) $display("FAIL relu_zp0: got %0d expected 0", got); else n_pass++;
        run_beat(-50, 1, 0, 10, 1'b1, got, e, g);
        n_checks++; if (got != 10) $display("FAIL relu_zp10: got %0d expected 10", got); else n_pass++;
        run_beat(-50, 1, 0, 10, 1'b0, got, e, g);
        n_checks++; if (got != -40) $display("FAIL norelu_zp10: got %0d expected -40", got); else n_pass++;
        n_checks++; if (sat_count !== 16'd0) $display("FAIL relu_not_sat: got sat_count %0d expected 0", sat_count); else n_pass++;
    endtask

    task automatic test_saturation();
        int got; bit e, g;
        run_beat(32767, 65535, 0, 0, 1'b0, got, e, g);
        n_checks++; if (got != 127) $display("FAIL sat_pos_value: got %0d expected 127", got); else n_pass++;
        n_checks++; if (sat_count !== 16'd1) $display("FAIL sat_pos_count: got %0d expected 1", sat_count); else n_pass++;
        run_beat(-32768, 65535, 0, 0, 1'b0, got, e, g);
        n_checks++; if (got != -128) $display("FAIL sat_neg_value: got %0d expected -128", got); else n_pass++;
        n_checks++; if (sat_count !== 16'd2) $display("FAIL sat_neg_count: got %0d expected 2", sat_count); else n_pass++;
    endtask

    task automatic test_sat_clear();
        int got; bit e, g;
        out_ready = 1'b1;
        set_beat(32767, 65535, 0, 0, 1'b0, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        sat_clear = 1'b1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL clear_pre_valid: got %0b expected 1", out_valid); else n_pass++;
        step();
        sat_clear = 1'b0;
        n_checks++; if (sat_count !== 16'd0) $display("FAIL clear_wins: got %0d expected 0", sat_count); else n_pass++;
        run_beat(-32768, 65535, 0, 0, 1'b0, got, e, g);
        n_checks++; if (sat_count !== 16'd1) $display("FAIL clear_then_count: got %0d expected 1", sat_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        int got_q[$];
        bit last_q[$];
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            set_beat(accepted + 1, 1, 0, 0, 1'b0, accepted == 3);
            #1;
            if (in_ready) accepted++;
            step();
        end
        #1;
        n_checks++; if (accepted != 2) $display("FAIL bp_accepts: got %0d expected 2", accepted); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %0b expected 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b1 || out_value !== 8'sd1) $display("FAIL bp_hold: got valid %0b value %0d expected 1/1", out_valid, out_value); else n_pass++;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got_q.size() < 4; c++) begin
            in_valid = (accepted < 4);
            if (accepted < 4) set_beat(accepted + 1, 1, 0, 0, 1'b0, accepted == 3);
            #1;
            if (out_valid) begin
                got_q.push_back(int'(out_value));
                last_q.push_back(out_last);
            end
            if (in_valid && in_ready) accepted++;
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (got_q.size() != 4) $display("FAIL bp_count: got %0d beats expected 4", got_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] != i + 1 || last_q[i] != (i == 3)) $display("FAIL bp_order[%0d]: got %0d last %0b expected %0d last %0b", i, got_q[i], last_q[i], i + 1, i == 3); else n_pass++;
        end
    endtask

    task automatic test_reset_midstream();
        int got; bit e, g;
        run_beat(32767, 65535, 0, 0, 1'b0, got, e, g);
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_beat(11, 1, 0, 0, 1'b0, 1'b0);
        step();
        set_beat(12, 1, 0, 0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || sat_count === 16'd0) $display("FAIL mid_pre: got valid %0b sat_count %0d expected 1 and nonzero", out_valid, sat_count); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_async_valid: got %0b expected 0", out_valid); else n_pass++;
        n_checks++; if (sat_count !== 16'd0) $display("FAIL mid_async_count: got %0d expected 0", sat_count); else n_pass++;
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %0b expected 1", in_ready); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_no_stale: got out_valid %0b expected 0", out_valid); else n_pass++;
        run_beat(7, 1, 0, 0, 1'b0, got, e, g);
        n_checks++; if (e !== 1'b0 || g !== 1'b1 || got != 7) $display("FAIL mid_after: got early %0b valid %0b value %0d expected 0/1/7", e, g, got); else n_pass++;
    endtask

    task automatic test_random();
        beat_t exp_q[$];
        beat_t b;
        int model_sat = 0;
        bit hold_prev = 1'b0;
        int prev_val = 0;
        bit prev_last = 1'b0;
        sat_clear = 1'b1;
        in_valid = 1'b0;
        step();
        sat_clear = 1'b0;
        for (int cyc = 0; cyc < 460; cyc++) begin
            if (cyc < 400) begin
                in_valid = ($urandom_range(0, 3) != 0);
                set_beat(int'($urandom),
                         ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 1023)),
                         int'($urandom_range(0, 31)), int'($urandom), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (hold_prev) begin
                n_checks++; if (out_valid !== 1'b1 || int'(out_value) != prev_val || out_last !== prev_last) $display("FAIL rnd_hold: got valid %0b value %0d last %0b expected 1/%0d/%0b", out_valid, out_value, out_last, prev_val, prev_last); else n_pass++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rnd_extra_beat: got value %0d expected no beat", out_value);
                end else begin
                    b = exp_q.pop_front();
                    if (b.sat) model_sat++;
                    n_checks++; if (int'(out_value) != b.val || out_last !== b.last) $display("FAIL rnd_beat: got %0d last %0b expected %0d last %0b", out_value, out_last, b.val, b.last); else n_pass++;
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_val  = int'(out_value);
            prev_last = out_last;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(in_value), int'(scale_mult), int'(scale_shift),
                                      int'(zero_point), relu_en, in_last));
            end
            step();
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL rnd_drain: got %0d beats outstanding expected 0", exp_q.size()); else n_pass++;
        n_checks++; if (int'(sat_count) != model_sat) $display("FAIL rnd_sat_count: got %0d expected %0d", sat_count, model_sat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_scaling();
        test_rounding();
        test_relu_zero_point();
        test_saturation();
        test_sat_clear();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/requant_relu_stage.md
Name: requant_relu_stage

Overview:
- Downstream consumer of the multiply-and-add array. Takes signed RESULT_WIDTH accumulator results and requantizes them to signed DATA_WIDTH activations for the next layer's input_value.
- Requantization: fixed-point scale, rounding shift, zero-point add, optional ReLU, saturation.
- 2-stage elastic pipeline with valid/ready on both sides, plus a saturation event counter for calibration.

Parameters:
- RESULT_WIDTH, 16: width of the incoming signed accumulator value.
- DATA_WIDTH, 8: width of the outgoing signed activation.
- MULT_WIDTH, 16: width of the unsigned scale multiplier.
- SHIFT_WIDTH, 5: width of the right-shift amount (0..2^SHIFT_WIDTH-1).
- COUNT_WIDTH, 16: width of the saturation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_value/in_last valid.
- in_ready  out  1  stage can accept a beat.
- in_value  in  RESULT_WIDTH  signed accumulator result.
- in_last  in  1  end-of-vector marker, passed through unchanged.
- scale_mult  in  MULT_WIDTH  unsigned multiplier, sampled with the beat.
- scale_shift  in  SHIFT_WIDTH  right shift, sampled with the beat.
- zero_point  in  DATA_WIDTH  signed output offset, sampled with the beat.
- relu_en  in  1  ReLU enable, sampled with the beat.
- out_valid  out  1  out_value valid.
- out_ready  in  1  downstream accepts.
- out_value  out  DATA_WIDTH  signed requantized activation.
- out_last  out  1  delayed in_last.
- sat_clear  in  1  synchronous clear of sat_count.
- sat_count  out  COUNT_WIDTH  number of saturated beats delivered.

Behaviour:
- Interface:
  - Clock and reset are decided: one clock, clk; reset rst_n, asynchronous, active-low.
  - Reset values: out_valid=0, out_value=0, out_last=0, sat_count=0, both stage-valid flags=0.
  - Reset mid-stream discards all in-flight beats. in_ready=1 in the first cycle after rst_n deasserts.
- Handshake:
  - A transfer occurs on a rising edge with valid&&ready on that side.
  - out_value/out_last are held stable while out_valid && !out_ready.
  - in_ready = !s1_valid || s1_advance.
  - s1_advance = !s2_valid || out_ready. Combinational path from out_ready to in_ready is permitted.
  - Full throughput (1 beat/cycle) when out_ready stays high.
  - Latency: accepted beat is presented on out_valid 2 cycles later.
  - Capacity: 2 beats. Beat order is preserved; no beat is lost or duplicated.
- Stage 1 (registers on accept):
  - product = in_value * {1'b0, scale_mult}, signed, RESULT_WIDTH+MULT_WIDTH+1 bits.
  - scale_shift, zero_point, relu_en and in_last are captured alongside.
- Stage 2 (registers when s1 advances):
  - If shift>0: r = (product + 2^(shift-1)) >>> shift (arithmetic; round half toward +inf).
  - If shift=0: r = product.
  - v = r + sign-extended zero_point. Intermediate widths must not overflow.
  - hi = 2^(DATA_WIDTH-1)-1.
  - lo = zero_point if relu_en, else -2^(DATA_WIDTH-1).
  - out_value = clamp(v, lo, hi).
  - sat flag = (v > hi) || (v < -2^(DATA_WIDTH-1)). A ReLU floor alone is not a saturation.
- sat_count:
  - Increments on each output transfer whose beat has sat=1.
  - Sticks at all-ones; no wrap.
  - sat_clear sets it to 0 next edge. Clear wins over a simultaneous increment.
- Config ports are per-beat and may change every cycle. Only values present at the input transfer apply to that beat.

Test Plan:
- Scaling with out_ready=1: in=200, mult=16384, shift=15, zp=0, relu=0 -> out=100 two cycles later, sat_count=0.
- Rounding: in=3, mult=1, shift=1 -> 2. in=-3, same config -> -1. in=5, shift=0 -> 5.
- ReLU and zero point:
  - in=-50, mult=1, shift=0, zp=0, relu=1 -> 0.
  - zp=10, relu=1 -> 10.
  - zp=10, relu=0 -> -40.
- Saturation and counter:
  - in=32767, mult=65535, shift=0 -> 127, sat_count=1.
  - in=-32768, mult=65535, shift=0 -> -128, sat_count=2.
  - Assert sat_clear in the same cycle as a saturated output transfer -> sat_count=0.
- Backpressure:
  - Stream in=1,2,3,4 (mult=1, shift=0), out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, out_value holds 1.
  - On out_ready=1 -> outputs 1,2,3,4 in order; in_last set only on beat 4 appears only with out=4.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0 asynchronously, sat_count=0; after release, next beat in=7 -> out=7 with latency 2.
